// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module      : branch_resolve_unit
// Description : Branch/jump resolution for the EX stage plus a direct-mapped
//               BTB with 2-bit saturating counters that feeds taken/target
//               predictions to IF. Drives the comparator's BrUn select,
//               raises a redirect on mispredict and counts mispredictions.
//               Optional feature macro: BTB_PREDICT_EN. When it is defined,
//               the BTB is built and predicts dynamically. When it is left
//               undefined, no table is built and prediction is static
//               not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // IF-stage lookup
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    // EX-stage resolve
    input  logic        ex_valid_i,
    input  logic        ex_branch_i,
    input  logic        ex_jump_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        BrEq_i,
    input  logic        BrLt_i,
    output logic        BrUn_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] mispredict_cnt_o
);

    localparam int c_IDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W = 32 - c_IDX_W - 2;

    // ------------------------------------------------------------------
    // Resolution (shared by both build variants)
    // ------------------------------------------------------------------
    logic        w_active;
    logic        w_taken;
    logic        w_legal;
    logic [31:0] w_exPcPlus4;
    logic [31:0] w_actualNext;
    logic        w_redirect;
    logic [31:0] r_mispredictCnt;

    // funct3 bit 1 separates the unsigned compares (BLTU/BGEU) from the rest
    assign BrUn_o = ex_funct3_i[1];

    assign w_active     = ex_valid_i & (ex_branch_i | ex_jump_i);
    assign w_exPcPlus4  = ex_pc_i + 32'd4;

    // Decode taken/not-taken from funct3 and the comparator flags; jumps win
    always_comb begin
        w_taken = 1'b0;
        w_legal = 1'b1;
        if (ex_jump_i) begin
            w_taken = 1'b1;
        end else begin
            case (ex_funct3_i)
                3'b000:          w_taken = BrEq_i;
                3'b001:          w_taken = ~BrEq_i;
                3'b100, 3'b110:  w_taken = BrLt_i;
                3'b101, 3'b111:  w_taken = ~BrLt_i;
                default: begin
                    // 010/011 are not branch encodings: fall through, never train
                    w_taken = 1'b0;
                    w_legal = 1'b0;
                end
            endcase
        end
    end

    assign w_actualNext  = w_taken ? ex_target_i : w_exPcPlus4;
    // Reset suppresses the redirect so fetch is not steered during reset
    assign w_redirect    = ~rst_i & w_active & (ex_pred_target_i != w_actualNext);
    assign redirect_o    = w_redirect;
    assign redirect_pc_o = w_redirect ? w_actualNext : 32'd0;

    // Saturating mispredict counter, advanced on each redirect cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mispredictCnt <= 32'd0;
        end else if (w_redirect && (r_mispredictCnt != 32'hFFFF_FFFF)) begin
            r_mispredictCnt <= r_mispredictCnt + 32'd1;
        end
    end

    assign mispredict_cnt_o = r_mispredictCnt;

`ifdef BTB_PREDICT_EN
    // ------------------------------------------------------------------
    // BTB storage and dynamic prediction
    // ------------------------------------------------------------------
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [1:0]             r_ctr    [BTB_ENTRIES];
    logic [c_TAG_W-1:0]     r_tag    [BTB_ENTRIES];
    logic [31:0]            r_target [BTB_ENTRIES];

    logic [c_IDX_W-1:0]     w_ifIdx;
    logic [c_TAG_W-1:0]     w_ifTag;
    logic                   w_ifHit;
    logic                   w_predTaken;

    logic [c_IDX_W-1:0]     w_exIdx;
    logic [c_TAG_W-1:0]     w_exTag;
    logic                   w_exHit;
    logic                   w_update;
    logic                   w_unused;

    assign w_ifIdx = if_pc_i[c_IDX_W+1:2];
    assign w_ifTag = if_pc_i[31:c_IDX_W+2];
    assign w_exIdx = ex_pc_i[c_IDX_W+1:2];
    assign w_exTag = ex_pc_i[31:c_IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not seen
    assign w_ifHit       = r_valid[w_ifIdx] & (r_tag[w_ifIdx] == w_ifTag);
    assign w_predTaken   = ~rst_i & if_valid_i & w_ifHit & r_ctr[w_ifIdx][1];
    assign pred_taken_o  = w_predTaken;
    assign pred_target_o = w_predTaken ? r_target[w_ifIdx] : (if_pc_i + 32'd4);

    assign w_exHit  = r_valid[w_exIdx] & (r_tag[w_exIdx] == w_exTag);
    assign w_update = ~rst_i & w_active & w_legal;

    // Valid bits and counters: reset to weakly-not-taken, train on resolve
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (w_update) begin
            if (w_exHit) begin
                if (ex_jump_i) begin
                    r_ctr[w_exIdx] <= 2'b11;
                end else if (w_taken) begin
                    if (r_ctr[w_exIdx] != 2'b11) begin
                        r_ctr[w_exIdx] <= r_ctr[w_exIdx] + 2'd1;
                    end
                end else if (r_ctr[w_exIdx] != 2'b00) begin
                    r_ctr[w_exIdx] <= r_ctr[w_exIdx] - 2'd1;
                end
            end else if (w_taken) begin
                r_valid[w_exIdx] <= 1'b1;
                r_ctr[w_exIdx]   <= ex_jump_i ? 2'b11 : 2'b10;
            end
        end
    end

    // Tag/target payload needs no reset: it is qualified by the valid bit
    always_ff @(posedge clk_i) begin
        if (w_update && w_taken) begin
            r_tag[w_exIdx]    <= w_exTag;
            r_target[w_exIdx] <= ex_target_i;
        end
    end

    assign w_unused = ex_pred_taken_i;
`else
    // ------------------------------------------------------------------
    // Static not-taken prediction, no table
    // ------------------------------------------------------------------
    logic w_unused;

    assign pred_taken_o  = 1'b0;
    assign pred_target_o = if_pc_i + 32'd4;

    assign w_unused = &{1'b0, ex_pred_taken_i, if_valid_i, w_legal};
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed bench for branch_resolve_unit with a behavioural
//               BTB/counter model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    localparam int N   = 16;
    localparam int IDX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifValid;
    logic [31:0] ifPc;
    logic        exValid, exBranch, exJump, exPredTaken, brEq, brLt;
    logic [2:0]  exF3;
    logic [31:0] exPc, exTarget, exPredTarget;
    logic        predTaken, brUn, redirect;
    logic [31:0] predTarget, redirectPc, mispCnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.BTB_ENTRIES(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_valid_i(ifValid), .if_pc_i(ifPc),
        .pred_taken_o(predTaken), .pred_target_o(predTarget),
        .ex_valid_i(exValid), .ex_branch_i(exBranch), .ex_jump_i(exJump),
        .ex_funct3_i(exF3), .ex_pc_i(exPc), .ex_target_i(exTarget),
        .ex_pred_taken_i(exPredTaken), .ex_pred_target_i(exPredTarget),
        .BrEq_i(brEq), .BrLt_i(brLt), .BrUn_o(brUn),
        .redirect_o(redirect), .redirect_pc_o(redirectPc),
        .mispredict_cnt_o(mispCnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          mReady = 0;
    bit          mValid [N];
    int unsigned mCtr   [N];
    logic [31:0] mTag   [N];
    logic [31:0] mTarget[N];
    logic [31:0] mCnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch outcome straight from the funct3 table
    function automatic bit outcome(output bit legal);
        legal = 1;
        if (exJump) return 1;
        if (exF3 == 3'd0) return brEq;
        if (exF3 == 3'd1) return !brEq;
        if (exF3 == 3'd4 || exF3 == 3'd6) return brLt;
        if (exF3 == 3'd5 || exF3 == 3'd7) return !brLt;
        legal = 0;
        return 0;
    endfunction

    function automatic logic [31:0] nextPc();
        bit lg;
        return outcome(lg) ? exTarget : exPc + 32'd4;
    endfunction

    function automatic bit isActive();
        return exValid && (exBranch || exJump);
    endfunction

    // Model state update at each clock edge
    always @(posedge clk) begin
        bit tk, lg;
        int unsigned ix;
        logic [31:0] tg;
        if (rst) begin
            mReady = 1;
            for (int i = 0; i < N; i++) begin mValid[i] = 0; mCtr[i] = 1; end
            mCnt = 0;
        end else if (mReady && isActive()) begin
            tk = outcome(lg);
            if (exPredTarget != nextPc() && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
            ix = (exPc >> 2) % N;
            tg = exPc >> (IDX + 2);
            if (lg) begin
                if (mValid[ix] && mTag[ix] == tg) begin
                    if (exJump) mCtr[ix] = 3;
                    else if (tk) mCtr[ix] = (mCtr[ix] == 3) ? 3 : mCtr[ix] + 1;
                    else mCtr[ix] = (mCtr[ix] == 0) ? 0 : mCtr[ix] - 1;
                    if (tk) mTarget[ix] = exTarget;
                end else if (tk) begin
                    mValid[ix] = 1; mTag[ix] = tg; mTarget[ix] = exTarget;
                    mCtr[ix] = exJump ? 3 : 2;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        bit          eTaken, eRed;
        logic [31:0] eTgt, eNext;
        int unsigned ix;
        if (mReady) begin
            ix = (ifPc >> 2) % N;
`ifdef BTB_PREDICT_EN
            eTaken = !rst && ifValid && mValid[ix] && mTag[ix] == (ifPc >> (IDX + 2)) && mCtr[ix] >= 2;
`else
            eTaken = 0;
`endif
            eTgt  = eTaken ? mTarget[ix] : ifPc + 32'd4;
            eNext = nextPc();
            eRed  = !rst && isActive() && (exPredTarget != eNext);
            chk("pred_taken", {31'd0, predTaken}, {31'd0, eTaken});
            chk("pred_target", predTarget, eTgt);
            if (exBranch) chk("BrUn", {31'd0, brUn}, {31'd0, exF3[1]});
            chk("redirect", {31'd0, redirect}, {31'd0, eRed});
            chk("redirect_pc", redirectPc, eRed ? eNext : 32'd0);
            chk("mispredict_cnt", mispCnt, mCnt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        ifValid = 1; ifPc = pc;
        exValid = 0; exBranch = 0; exJump = 0; exF3 = 0; exPc = 0; exTarget = 0;
        exPredTaken = 0; exPredTarget = 0; brEq = 0; brLt = 0;
    endtask

    task automatic ex(input bit v, input bit br, input bit j, input logic [2:0] f3,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input logic [31:0] ptgt, input bit eq, input bit lt);
        exValid = v; exBranch = br; exJump = j; exF3 = f3; exPc = pc; exTarget = tgt;
        exPredTarget = ptgt; exPredTaken = (ptgt != pc + 32'd4); brEq = eq; brLt = lt;
    endtask

    task automatic predLit(input string name, input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        idle(pc);
        #2;
`ifdef BTB_PREDICT_EN
        chk({name, "_taken"}, {31'd0, predTaken}, {31'd0, tk});
        chk({name, "_target"}, predTarget, tgt);
`else
        chk({name, "_taken"}, {31'd0, predTaken}, 32'd0);
        chk({name, "_target"}, predTarget, pc + 32'd4);
`endif
        tick();
    endtask

    initial begin
        rst = 1;
        idle(32'h100);
        tick(); tick();
        rst = 0;
        #2;
        chk("reset_redirect", {31'd0, redirect}, 32'd0);
        chk("reset_redirect_pc", redirectPc, 32'd0);
        chk("reset_cnt", mispCnt, 32'd0);
        chk("reset_pred_taken", {31'd0, predTaken}, 32'd0);
        chk("reset_pred_target", predTarget, 32'h104);
        tick();

        // BEQ taken, predicted not-taken -> redirect to 0x140
        ex(1, 1, 0, 3'b000, 32'h100, 32'h140, 32'h104, 1, 0);
        #2;
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_redirect_pc", redirectPc, 32'h140);
        chk("beq_brun", {31'd0, brUn}, 32'd0);
        tick();
        #2 chk("beq_cnt", mispCnt, 32'd1);
        predLit("beq_pred", 32'h100, 1, 32'h140);

        // BLTU not taken, correctly predicted -> no redirect, no allocation
        ex(1, 1, 0, 3'b110, 32'h200, 32'h240, 32'h204, 0, 0);
        #2;
        chk("bltu_brun", {31'd0, brUn}, 32'd1);
        chk("bltu_redirect", {31'd0, redirect}, 32'd0);
        tick();
        predLit("bltu_pred", 32'h200, 0, 32'h204);

        // BNE at 0x184: taken x3 then not-taken x2
        ex(1, 1, 0, 3'b001, 32'h184, 32'h1c0, 32'h188, 0, 0); tick();
        ex(1, 1, 0, 3'b001, 32'h184, 32'h1c0, 32'h1c0, 0, 0); tick();
        ex(1, 1, 0, 3'b001, 32'h184, 32'h1c0, 32'h1c0, 0, 0); tick();
        ex(1, 1, 0, 3'b001, 32'h184, 32'h1c0, 32'h1c0, 1, 0);
        #2 chk("bne_nt_redirect_pc", redirectPc, 32'h188);
        tick();
        predLit("bne_after_one_nt", 32'h184, 1, 32'h1c0);
        ex(1, 1, 0, 3'b001, 32'h184, 32'h1c0, 32'h188, 1, 0); tick();
        predLit("bne_after_two_nt", 32'h184, 0, 32'h188);

        // Aliasing: 0x140 shares index 0 with 0x100 and evicts it
        ex(1, 1, 0, 3'b000, 32'h140, 32'h400, 32'h144, 1, 0); tick();
        predLit("alias_old", 32'h100, 0, 32'h104);
        predLit("alias_new", 32'h140, 1, 32'h400);

        // Same-cycle lookup and update at 0x300: lookup sees old entry
        ex(1, 0, 1, 3'b000, 32'h300, 32'h500, 32'h304, 0, 0);
        ifPc = 32'h300;
        #2;
        chk("samecyc_old_taken", {31'd0, predTaken}, 32'd0);
        chk("samecyc_old_target", predTarget, 32'h304);
        tick();
        predLit("samecyc_new", 32'h300, 1, 32'h500);

        // Bubble with branch asserted: nothing happens
        ex(0, 1, 0, 3'b000, 32'h100, 32'h900, 32'h104, 1, 0);
        #2 chk("bubble_redirect", {31'd0, redirect}, 32'd0);
        tick();
        #2 chk("bubble_cnt", mispCnt, 32'd5);
        tick();

        // Illegal funct3: falls through, redirect only if pred_target wrong
        ex(1, 1, 0, 3'b010, 32'h600, 32'h700, 32'h700, 1, 1);
        #2 chk("f3_010_redirect_pc", redirectPc, 32'h604);
        tick();
        predLit("f3_010_noalloc", 32'h600, 0, 32'h604);

        // Reset during a mispredict
        ex(1, 1, 0, 3'b000, 32'h100, 32'h140, 32'h104, 1, 0);
        rst = 1;
        #2 chk("rst_mid_redirect", {31'd0, redirect}, 32'd0);
        tick();
        rst = 0;
        idle(32'h300);
        #2;
        chk("rst_mid_cnt", mispCnt, 32'd0);
        chk("rst_mid_pred", {31'd0, predTaken}, 32'd0);
        tick();

        // JAL 0x10 -> 0x80
        ex(1, 0, 1, 3'b000, 32'h10, 32'h80, 32'h14, 0, 0);
        #2;
        chk("jal_redirect", {31'd0, redirect}, 32'd1);
        chk("jal_redirect_pc", redirectPc, 32'h80);
        tick();
        // Jump with correct predicted target
        ex(1, 0, 1, 3'b000, 32'h10, 32'h80, 32'h80, 0, 0);
        #2 chk("jal_hit_redirect", {31'd0, redirect}, 32'd0);
        tick();
        predLit("jal_pred", 32'h10, 1, 32'h80);
        // BGE signed, taken on !BrLt
        ex(1, 1, 0, 3'b101, 32'h20, 32'h60, 32'h24, 0, 0);
        #2 chk("bge_redirect_pc", redirectPc, 32'h60);
        tick();
        idle(32'h0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch prediction and resolution stage for the pipelined RV32I core. It directly consumes the `BrEq`/`BrLt` flags from the branch comparator in EX and drives the comparator's `BrUn` select. It then decides branch/jump outcome, detects mispredictions, and issues a redirect to fetch. A small direct-mapped BTB with 2-bit saturating counters supplies taken/target predictions to the IF stage.

## Interface
- `BTB_ENTRIES`, default 16: BTB depth; power of two, 4..64; IDX = log2(BTB_ENTRIES).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `if_valid_i`  in  1  IF-stage PC is valid.
- `if_pc_i`  in  32  IF-stage PC.
- `pred_taken_o`  out  1  prediction: taken.
- `pred_target_o`  out  32  predicted next PC.
- `ex_valid_i`  in  1  EX instruction is valid (not a bubble).
- `ex_branch_i`  in  1  EX instruction is a conditional branch.
- `ex_jump_i`  in  1  EX instruction is JAL/JALR.
- `ex_funct3_i`  in  3  branch funct3.
- `ex_pc_i`  in  32  EX instruction PC.
- `ex_target_i`  in  32  computed branch/jump target from the ALU.
- `ex_pred_taken_i`  in  1  prediction made at fetch, piped to EX.
- `ex_pred_target_i`  in  32  predicted next PC, piped to EX.
- `BrEq_i`  in  1  comparator equal flag.
- `BrLt_i`  in  1  comparator less-than flag.
- `BrUn_o`  out  1  unsigned-compare select to comparator.
- `redirect_o`  out  1  mispredict; flush IF/ID, load `redirect_pc_o`.
- `redirect_pc_o`  out  32  correct next PC.
- `mispredict_cnt_o`  out  32  count of mispredictions.

## Operation
- Indexing: index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Each entry holds valid, tag, target[31:0], and ctr[1:0].
- Prediction is combinational from registered state:
  - hit = valid & tag match.
  - `pred_taken_o` = `if_valid_i` & hit & ctr[1].
  - `pred_target_o` = target when `pred_taken_o` is 1, else `if_pc_i`+4 (modulo 2^32).
- `BrUn_o` = `ex_funct3_i`[1]. It is combinational and valid whenever `ex_branch_i` is 1.
- Outcome `taken` for branches, by funct3:
  - 000: BrEq
  - 001: ~BrEq
  - 100 and 110: BrLt
  - 101 and 111: ~BrLt
  - 010 and 011: not taken, and no table update.
- Jumps: `taken` = 1.
- Resolution is active only when `ex_valid_i` & (`ex_branch_i` | `ex_jump_i`).
  - actual_next = taken ? `ex_target_i` : `ex_pc_i`+4.
  - `redirect_o` = active & (`ex_pred_target_i` != actual_next).
  - `redirect_pc_o` = actual_next. It is don't-care when `redirect_o` is 0 and is driven to 0 in that case.
- Table update on the clock edge, for active resolutions with legal funct3:
  - Hit: ctr increments on taken (saturates at 11) and decrements on not-taken (saturates at 00). Target is rewritten on taken.
  - Hit on a jump: ctr is forced to 11.
  - Miss and taken: allocate the entry with valid=1, new tag and target, ctr=10 (11 for jumps). Any existing entry at that index is overwritten.
  - Miss and not taken: no change.
- `mispredict_cnt_o` increments on every cycle where `redirect_o`=1. It saturates at 0xFFFF_FFFF.

## Timing
- Prediction: 0-cycle latency, same cycle as `if_pc_i`.
- Redirect: 0-cycle, combinational in the EX cycle. Fetch loads `redirect_pc_o` on the following edge.
- Table and counter writes take effect at the edge ending the resolve cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry. There is no bypass.
- Reset (`rst_i`=1 at an edge), including mid-operation:
  - All valid bits clear, all ctr are set to 01, and `mispredict_cnt_o`=0.
  - While `rst_i`=1, `redirect_o`=0 and `pred_taken_o`=0. No table update occurs that cycle.
- Reset values: `pred_taken_o`=0; `pred_target_o`=`if_pc_i`+4; `redirect_o`=0; `redirect_pc_o`=0; `mispredict_cnt_o`=0.
- `ex_valid_i`=0: no redirect, no update, and no counter change, regardless of the other EX inputs.

## Configuration
- `BTB_PREDICT_EN` defined: BTB storage and dynamic prediction operate as described above.
- `BTB_PREDICT_EN` undefined:
  - No table storage is built.
  - `pred_taken_o` is tied to 0 and `pred_target_o` = `if_pc_i`+4 (static not-taken).
  - Resolution, redirect, `BrUn_o`, and `mispredict_cnt_o` behave identically. In effect, every taken branch and every jump mispredicts.

## Test plan
- Reset, then a BEQ at pc 0x100 with BrEq=1, target 0x140, pred_taken=0, pred_target=0x104: expect `redirect_o`=1, `redirect_pc_o`=0x140, count=1. Next cycle, IF pc 0x100 returns pred_taken=1 with target 0x140.
- BLTU at pc 0x200, funct3=110: expect `BrUn_o`=1. With BrLt=0 and pred_target 0x204: expect no redirect and no allocation.
- Resolve the same BNE as taken 3 times, then not-taken once: ctr goes 10→11→11→10 and the prediction stays taken. A second not-taken gives ctr 01, so pred_taken=0.
- Aliasing: a taken branch at 0x100, then a taken branch at 0x140 (BTB_ENTRIES=16, same index). The second overwrites the first, so IF at 0x100 misses and predicts pc+4.
- Same-cycle update and lookup at pc 0x300: the lookup shows the old entry, and the next cycle shows the new one. `ex_valid_i`=0 with branch=1: no redirect and the count is unchanged.
- Assert `rst_i` in a mispredict cycle: `redirect_o`=0, and the table and count are cleared on that edge. With `BTB_PREDICT_EN` undefined, a JAL from 0x10 to 0x80 gives `redirect_o`=1 and `redirect_pc_o`=0x80.
